// File: rtl/shared_timer_arb.sv
// Two-channel arbiter for one shared prescaled countdown timer: the granted owner gets a
// one-cycle expire pulse when its count runs out, unless it drops its request first.
module shared_timer_arb #(
  parameter int W        = 8,
  parameter int PRESCALE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req,
  input  logic [W-1:0] load0,
  input  logic [W-1:0] load1,
  output logic [1:0]   gnt,
  output logic [1:0]   expire,
  output logic         busy,
  output logic [W-1:0] count,
  output logic [1:0]   state_o
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic [W-1:0]  count_q, count_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          winner;

  // Single requester wins outright; on a tie the channel that did not own last time wins.
  assign winner = (req == 2'b10) || ((req == 2'b11) && !last_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      count_q <= '0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      count_q <= count_d;
      presc_q <= presc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    count_d = count_q;
    presc_d = presc_q;
    case (state_q)
      IDLE: begin
        count_d = '0;
        presc_d = '0;
        if (req != 2'b00) begin
          state_d = RUN;
          owner_d = winner;
          count_d = winner ? load1 : load0;
        end
      end
      RUN: begin
        // Owner dropping its request wins over reaching zero in the same cycle.
        if (!req[owner_q]) begin
          state_d = IDLE;
          last_d  = owner_q;
          count_d = '0;
          presc_d = '0;
        end else if (count_q == '0) begin
          state_d = DONE;
        end else if (presc_q == PMAX) begin
          presc_d = '0;
          count_d = count_q - W'(1);
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        last_d  = owner_q;
        count_d = '0;
        presc_d = '0;
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
        presc_d = '0;
      end
    endcase
  end

  logic [1:0] owner_oh;
  assign owner_oh = owner_q ? 2'b10 : 2'b01;

  assign gnt     = (state_q == RUN || state_q == DONE) ? owner_oh : 2'b00;
  assign expire  = (state_q == DONE) ? owner_oh : 2'b00;
  assign busy    = (state_q != IDLE);
  assign count   = (state_q == IDLE) ? '0 : count_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_shared_timer_arb.sv
// Directed vector table for shared_timer_arb (W=8, PRESCALE=4) plus hand sequences
// for asynchronous reset mid-RUN and the full-scale load value.
module tb_shared_timer_arb;

  logic       clk;
  logic       rst;
  logic [1:0] req;
  logic [7:0] load0, load1;
  logic [1:0] gnt, expire;
  logic       busy;
  logic [7:0] count;
  logic [1:0] state_o;

  int tests_run;
  int tests_failed;

  shared_timer_arb #(.W(8), .PRESCALE(4)) dut (
    .clk(clk), .rst(rst), .req(req), .load0(load0), .load1(load1),
    .gnt(gnt), .expire(expire), .busy(busy), .count(count), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] req;
    logic [7:0] l0;
    logic [7:0] l1;
    logic [1:0] gnt;
    logic [1:0] exp;
    logic       busy;
    logic [7:0] cnt;
    logic [1:0] st;
  } vec_t;

  vec_t vecs[$];

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  function automatic void v(input logic [1:0] rq, input logic [7:0] a, input logic [7:0] b,
                            input logic [1:0] g, input logic [1:0] e, input logic bz,
                            input logic [7:0] c, input logic [1:0] s);
    vec_t t;
    t.req = rq; t.l0 = a; t.l1 = b; t.gnt = g; t.exp = e; t.busy = bz; t.cnt = c; t.st = s;
    vecs.push_back(t);
  endfunction

  task automatic check_outs(input string name, input logic [1:0] g, input logic [1:0] e,
                            input logic bz, input logic [7:0] c, input logic [1:0] s);
    tests_run++;
    if ({gnt, expire, busy, count, state_o} !== {g, e, bz, c, s}) begin
      tests_failed++;
      $display("FAIL %s: got gnt=%b expire=%b busy=%b count=%0d state=%b, want gnt=%b expire=%b busy=%b count=%0d state=%b",
               name, gnt, expire, busy, count, state_o, g, e, bz, c, s);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int runs;
    tests_run = 0;
    tests_failed = 0;

    // Tie right after reset: channel 0 first, then channel 1 after req0 drops.
    v(2'b11, 8'd0, 8'd0, 2'b01, 2'b00, 1'b1, 8'd0, S_RUN);
    v(2'b11, 8'd0, 8'd0, 2'b01, 2'b01, 1'b1, 8'd0, S_DONE);
    v(2'b10, 8'd0, 8'd0, 2'b00, 2'b00, 1'b0, 8'd0, S_IDLE);
    v(2'b10, 8'd0, 8'd0, 2'b10, 2'b00, 1'b1, 8'd0, S_RUN);
    v(2'b10, 8'd0, 8'd0, 2'b10, 2'b10, 1'b1, 8'd0, S_DONE);
    v(2'b00, 8'd0, 8'd0, 2'b00, 2'b00, 1'b0, 8'd0, S_IDLE);
    // load0=3: decrement every 4 cycles, load0 changes after grant ignored.
    v(2'b01, 8'd3, 8'd0, 2'b01, 2'b00, 1'b1, 8'd3, S_RUN);
    for (int i = 1; i <= 12; i++)
      v(2'b01, 8'd9, 8'd0, 2'b01, 2'b00, 1'b1, 8'(3 - i / 4), S_RUN);
    v(2'b01, 8'd9, 8'd0, 2'b01, 2'b01, 1'b1, 8'd0, S_DONE);
    v(2'b00, 8'd9, 8'd0, 2'b00, 2'b00, 1'b0, 8'd0, S_IDLE);
    // Held tie with zero loads: grants alternate, last owner was channel 0.
    v(2'b11, 8'd0, 8'd0, 2'b10, 2'b00, 1'b1, 8'd0, S_RUN);
    v(2'b11, 8'd0, 8'd0, 2'b10, 2'b10, 1'b1, 8'd0, S_DONE);
    v(2'b11, 8'd0, 8'd0, 2'b00, 2'b00, 1'b0, 8'd0, S_IDLE);
    v(2'b11, 8'd0, 8'd0, 2'b01, 2'b00, 1'b1, 8'd0, S_RUN);
    v(2'b11, 8'd0, 8'd0, 2'b01, 2'b01, 1'b1, 8'd0, S_DONE);
    v(2'b11, 8'd0, 8'd0, 2'b00, 2'b00, 1'b0, 8'd0, S_IDLE);
    v(2'b11, 8'd0, 8'd0, 2'b10, 2'b00, 1'b1, 8'd0, S_RUN);
    // Owner 1 drops req in its count==0 RUN cycle: abort, no expire.
    v(2'b01, 8'd0, 8'd0, 2'b00, 2'b00, 1'b0, 8'd0, S_IDLE);
    // load0=5, non-owner toggles req, owner drops after 6 more cycles.
    v(2'b01, 8'd5, 8'd0, 2'b01, 2'b00, 1'b1, 8'd5, S_RUN);
    for (int i = 1; i <= 6; i++)
      v((i % 2 == 1) ? 2'b11 : 2'b01, 8'd5, 8'd0, 2'b01, 2'b00, 1'b1, 8'(5 - i / 4), S_RUN);
    v(2'b00, 8'd5, 8'd0, 2'b00, 2'b00, 1'b0, 8'd0, S_IDLE);

    rst = 1'b1;
    req = 2'b00;
    load0 = 8'd0;
    load1 = 8'd0;
    #2;
    check_outs("reset_state", 2'b00, 2'b00, 1'b0, 8'd0, S_IDLE);
    #10;
    rst = 1'b0;

    foreach (vecs[i]) begin
      req = vecs[i].req;
      load0 = vecs[i].l0;
      load1 = vecs[i].l1;
      tick();
      check_outs($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].exp, vecs[i].busy,
                 vecs[i].cnt, vecs[i].st);
    end

    // Asynchronous reset mid-RUN at count=2.
    req = 2'b01;
    load0 = 8'd3;
    tick();
    repeat (4) tick();
    check_outs("pre_rst_count2", 2'b01, 2'b00, 1'b1, 8'd2, S_RUN);
    #3;
    rst = 1'b1;
    #1;
    check_outs("async_rst_immediate", 2'b00, 2'b00, 1'b0, 8'd0, S_IDLE);
    req = 2'b00;
    tick();
    rst = 1'b0;
    tick();
    check_outs("after_rst_release", 2'b00, 2'b00, 1'b0, 8'd0, S_IDLE);

    // Full-scale load: RUN dwell 255*4+1 cycles, then DONE with expire.
    req = 2'b01;
    load0 = 8'd255;
    tick();
    check_outs("max_load_entry", 2'b01, 2'b00, 1'b1, 8'd255, S_RUN);
    load0 = 8'd0;
    runs = 1;
    for (int n = 0; n < 2000; n++) begin
      tick();
      if (state_o != S_RUN) break;
      runs++;
    end
    tests_run++;
    if (runs != 1021) begin
      tests_failed++;
      $display("FAIL max_load_dwell: got %0d RUN cycles, want 1021", runs);
    end
    check_outs("max_load_done", 2'b01, 2'b01, 1'b1, 8'd0, S_DONE);
    req = 2'b00;
    tick();
    check_outs("max_load_idle", 2'b00, 2'b00, 1'b0, 8'd0, S_IDLE);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/shared_timer_arb.md
SHARED_TIMER_ARB -- requirements
Module: shared_timer_arb

Interface
REQ-001 Parameter W, default 8: width of the countdown counter and of the load values.
REQ-002 Parameter PRESCALE, default 4, legal range >= 1: clk cycles per counter decrement.
REQ-003 Clock clk, reset rst, asynchronous, active-high.
REQ-004 clk  in  1  system clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 req  in  2  per-channel timer request (level); bit i is channel i.
REQ-007 load0  in  W  timeout count for channel 0, sampled only at grant.
REQ-008 load1  in  W  timeout count for channel 1, sampled only at grant.
REQ-009 gnt  out  2  one-hot grant (level); bit i is high while channel i owns the timer (RUN or DONE).
REQ-010 expire  out  2  one-cycle timeout pulse to the owner; high in the DONE cycle only.
REQ-011 busy  out  1  high when state is not IDLE.
REQ-012 count  out  W  current countdown value.
REQ-013 state_o  out  2  state encoding: IDLE=00, RUN=01, DONE=10.

Function
REQ-014 The block SHALL implement the FSM IDLE, RUN and DONE; encoding 11 SHALL go to IDLE on the next edge.
REQ-015 In IDLE with req != 0, the block SHALL select a winner: the single requester, or on a tie the channel != last_owner.
REQ-016 On the IDLE->RUN edge, the block SHALL set owner=winner, load count from the winner's load value, and clear the prescaler to 0.
REQ-017 In RUN with count != 0, the prescaler SHALL increment each cycle.
REQ-018 When the prescaler equals PRESCALE-1, it SHALL wrap to 0 and count SHALL decrement by 1.
REQ-019 In RUN with count == 0, the next state SHALL be DONE; total RUN dwell SHALL be N*PRESCALE+1 cycles for load value N.
REQ-020 Load value 0 SHALL give one RUN cycle followed by DONE; load 2^W-1 SHALL be legal, with no wrap below 0.
REQ-021 DONE SHALL last exactly one cycle and then go to IDLE, setting last_owner=owner.
REQ-022 In RUN, req[owner]==0 SHALL abort: next state IDLE, no expire pulse, last_owner=owner.
REQ-023 Abort SHALL take priority over the RUN->DONE transition in the same cycle.
REQ-024 A req change by the non-owner during RUN/DONE SHALL have no effect; the non-owner waits.
REQ-025 If the owner still asserts req on return to IDLE, it SHALL re-arbitrate normally, so a waiting peer wins.
REQ-026 count SHALL be forced to 0 in IDLE.
REQ-027 Arbitration SHALL use one IDLE cycle: no back-to-back grant from DONE directly to RUN.
REQ-028 load0 and load1 changes after grant SHALL be ignored.

Reset
REQ-029 rst=1 SHALL immediately force state IDLE, gnt=00, expire=00, busy=0, count=0, prescaler=0, and last_owner=1, so channel 0 wins the first tie.
REQ-030 Reset asserted mid-RUN SHALL discard the pending timeout without emitting an expire pulse.

Verification (W=8, PRESCALE=4)
REQ-031 Scenario: req=01, load0=3 in IDLE -> gnt=01 from next cycle (RUN entry k), count 3->2->1->0 at k+4/k+8/k+12, expire=01 only at k+13, IDLE at k+14.
REQ-032 Scenario: req=11 right after reset -> channel 0 granted first; after expire0 and req0 drop, one IDLE cycle, then gnt=10.
REQ-033 Scenario: req=11 held continuously, load0=load1=0 -> grants alternate 01,10,01,...; each expire pulse is one cycle; no channel is granted twice in a row.
REQ-034 Scenario: load1=0, req=10 -> one RUN cycle, DONE with expire=10, IDLE.
REQ-035 Scenario: load0=5, req0 dropped 6 cycles into RUN -> IDLE next cycle, expire stays 00, count=0; dropping req0 in the count==0 cycle also gives no expire.
REQ-036 Scenario: rst pulsed asynchronously mid-RUN (count=2) -> all outputs 0 before the next clk edge; state_o=00 after release.
